// File: rtl/milano_pkg.sv
// milano_pkg: shared types for the milano core execution units.
//   md_opt_e    : M-extension operation select (funct3 order)
//   mdu_state_e : state encoding of the milano_mdu control FSM
//   is_div_op() : true for DIV/DIVU/REM/REMU
package milano_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_opt_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_div_op(input md_opt_e op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

endpackage

// File: rtl/milano_mdu_div_iter.sv
// milano_mdu_div_iter: unsigned radix-2 restoring divider, one quotient bit
// per clock. Operands are magnitudes; sign handling lives in the caller.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : load operands and begin XLEN iterations
//   i_flush        : abandon the current division
//   i_dividend     : dividend magnitude
//   i_divisor      : divisor magnitude (non-zero; zero is handled upstream)
//   o_quotient     : quotient, valid while o_done
//   o_remainder    : remainder, valid while o_done
//   o_done         : XLEN iterations have completed
module milano_mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_done
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN-1:0]  r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_trial;
  logic             w_fits;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in XLEN+1 bits and bit XLEN of the difference is a clean borrow flag.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[XLEN];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_dvs    <= i_divisor;
      r_cnt    <= CNT_W'(XLEN);
      r_active <= 1'b1;
    end else if (r_active && (r_cnt != '0)) begin
      r_rem <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_done      = r_active && (r_cnt == '0);

endmodule

// File: rtl/milano_mdu.sv
// milano_mdu: RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_*             : request channel (op, operands a/b, destination rd)
//   kill_i            : flush the in-flight operation, no response
//   resp_*            : result channel toward rd write-back
//   busy_o            : an operation is in flight
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready_o is high only in IDLE. Once resp_valid_o is high,
// resp_data_o/resp_rd_addr_o hold until resp_ready_i is seen (or a kill).
// The request channel reopens in the cycle after the response handshake.
module milano_mdu
  import milano_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1,
  parameter int RADDR_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  md_opt_e            req_op_i,
  input  logic [XLEN-1:0]    req_a_i,
  input  logic [XLEN-1:0]    req_b_i,
  input  logic [RADDR_W-1:0] req_rd_addr_i,
  input  logic               kill_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [RADDR_W-1:0] resp_rd_addr_o,
  output logic [XLEN-1:0]    resp_data_o,
  output logic               busy_o
);

  localparam int MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mdu_state_e         r_state;
  md_opt_e            r_op;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic               r_a_neg;
  logic               r_b_neg;
  logic [RADDR_W-1:0] r_rd;
  logic [MCNT_W-1:0]  r_mul_cnt;
  logic               r_resp_valid;
  logic [XLEN-1:0]    r_resp_data;
  logic [RADDR_W-1:0] r_resp_rd;

  // Request-side decode (operates on the live request inputs).
  logic            w_accept;
  logic            w_signed_div;
  logic            w_is_rem_in;
  logic            w_a_neg_in;
  logic            w_b_neg_in;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_data;
  logic            w_div_start;

  // kill_i blocks a same-cycle accept even though it is otherwise ignored in IDLE.
  assign w_accept     = req_valid_i && (r_state == MDU_IDLE) && !kill_i;
  assign w_signed_div = (req_op_i == MD_DIV) || (req_op_i == MD_REM);
  assign w_is_rem_in  = (req_op_i == MD_REM) || (req_op_i == MD_REMU);
  assign w_a_neg_in   = w_signed_div && req_a_i[XLEN-1];
  assign w_b_neg_in   = w_signed_div && req_b_i[XLEN-1];
  // The most negative value maps onto itself, which read unsigned is the right magnitude.
  assign w_a_abs      = w_a_neg_in ? -req_a_i : req_a_i;
  assign w_b_abs      = w_b_neg_in ? -req_b_i : req_b_i;
  assign w_div_zero   = (req_b_i == '0);
  assign w_ovf        = w_signed_div && (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b_i);
  assign w_fast       = is_div_op(req_op_i) && (w_div_zero || w_ovf);
  assign w_fast_data  = w_div_zero ? (w_is_rem_in ? req_a_i : '1)
                                   : (w_is_rem_in ? '0      : req_a_i);
  assign w_div_start  = w_accept && is_div_op(req_op_i) && !w_fast;

  // Multiply on registered operands. Widening to 2*XLEN with the sign (or
  // zero) bit matches the XLEN+1-bit extension; the low 2*XLEN product bits
  // are exact for every signedness mix, so no separate negate is needed.
  logic            w_mul_a_sgn;
  logic            w_mul_b_sgn;
  logic [2*XLEN-1:0] w_mul_a_wide;
  logic [2*XLEN-1:0] w_mul_b_wide;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_mul_res;

  assign w_mul_a_sgn  = ((r_op == MD_MULH) || (r_op == MD_MULHSU)) && r_a[XLEN-1];
  assign w_mul_b_sgn  = (r_op == MD_MULH) && r_b[XLEN-1];
  assign w_mul_a_wide = {{XLEN{w_mul_a_sgn}}, r_a};
  assign w_mul_b_wide = {{XLEN{w_mul_b_sgn}}, r_b};
  assign w_prod       = w_mul_a_wide * w_mul_b_wide;
  assign w_mul_res    = (r_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Divide core and sign fix-up.
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_res;

  milano_mdu_div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_start     (w_div_start),
    .i_flush     (kill_i),
    .i_dividend  (w_a_abs),
    .i_divisor   (w_b_abs),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  assign w_div_res = ((r_op == MD_REM) || (r_op == MD_REMU))
                   ? (r_a_neg ? -w_rem : w_rem)
                   : ((r_a_neg ^ r_b_neg) ? -w_quo : w_quo);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= MDU_IDLE;
      r_op         <= MD_MUL;
      r_a          <= '0;
      r_b          <= '0;
      r_a_neg      <= 1'b0;
      r_b_neg      <= 1'b0;
      r_rd         <= '0;
      r_mul_cnt    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op_i;
            r_a     <= req_a_i;
            r_b     <= req_b_i;
            r_a_neg <= w_a_neg_in;
            r_b_neg <= w_b_neg_in;
            r_rd    <= req_rd_addr_i;
            if (!is_div_op(req_op_i)) begin
              r_mul_cnt <= MCNT_W'(MUL_CYCLES - 1);
              r_state   <= MDU_MUL;
            end else if (w_fast) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_fast_data;
              r_resp_rd    <= req_rd_addr_i;
              r_state      <= MDU_DONE;
            end else begin
              r_state <= MDU_DIV;
            end
          end
        end
        MDU_MUL: begin
          if (kill_i) begin
            r_state <= MDU_IDLE;
          end else if (r_mul_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_mul_res;
            r_resp_rd    <= r_rd;
            r_state      <= MDU_DONE;
          end else begin
            r_mul_cnt <= r_mul_cnt - MCNT_W'(1);
          end
        end
        MDU_DIV: begin
          if (kill_i) begin
            r_state <= MDU_IDLE;
          end else if (w_div_done) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_div_res;
            r_resp_rd    <= r_rd;
            r_state      <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          // A kill alongside a completed handshake still counts as delivered.
          if (kill_i || resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= MDU_IDLE;
          end
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign req_ready_o    = (r_state == MDU_IDLE);
  assign busy_o         = (r_state != MDU_IDLE);
  assign resp_valid_o   = r_resp_valid;
  assign resp_data_o    = r_resp_data;
  assign resp_rd_addr_o = r_resp_rd;

endmodule

// File: tb/tb_milano_mdu.sv
module tb_milano_mdu;
  import milano_pkg::*;

  logic        clk;
  logic        rst;
  md_opt_e     req_op;
  logic [4:0]  req_rd;
  logic        kill;
  logic        resp_ready;

  logic        req_valid32;
  logic [31:0] req_a32;
  logic [31:0] req_b32;
  logic        req_ready32;
  logic        resp_valid32;
  logic [4:0]  resp_rd32;
  logic [31:0] resp_data32;
  logic        busy32;

  logic        req_valid64;
  logic [63:0] req_a64;
  logic [63:0] req_b64;
  logic        req_ready64;
  logic        resp_valid64;
  logic [4:0]  resp_rd64;
  logic [63:0] resp_data64;
  logic        busy64;

  int n_cmp;
  int n_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  milano_mdu #(.XLEN(32), .MUL_CYCLES(1), .RADDR_W(5)) u_dut32 (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid32),
    .req_ready_o    (req_ready32),
    .req_op_i       (req_op),
    .req_a_i        (req_a32),
    .req_b_i        (req_b32),
    .req_rd_addr_i  (req_rd),
    .kill_i         (kill),
    .resp_valid_o   (resp_valid32),
    .resp_ready_i   (resp_ready),
    .resp_rd_addr_o (resp_rd32),
    .resp_data_o    (resp_data32),
    .busy_o         (busy32)
  );

  milano_mdu #(.XLEN(64), .MUL_CYCLES(3), .RADDR_W(5)) u_dut64 (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid64),
    .req_ready_o    (req_ready64),
    .req_op_i       (req_op),
    .req_a_i        (req_a64),
    .req_b_i        (req_b64),
    .req_rd_addr_i  (req_rd),
    .kill_i         (kill),
    .resp_valid_o   (resp_valid64),
    .resp_ready_i   (resp_ready),
    .resp_rd_addr_o (resp_rd64),
    .resp_data_o    (resp_data64),
    .busy_o         (busy64)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance and check the result, its
  // latency in edges after the accepting edge, rd and the handshake.
  task automatic run_op(input bit w64, input string tag, input md_opt_e op,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    check_val({tag, "_req_ready"}, w64 ? req_ready64 : req_ready32, 1'b1);
    req_op = op;
    req_rd = rd;
    if (w64) begin
      req_a64 = a; req_b64 = b; req_valid64 = 1'b1;
    end else begin
      req_a32 = a[31:0]; req_b32 = b[31:0]; req_valid32 = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
    // disturb the operands: the in-flight operation must not see this
    req_a32 = ~req_a32; req_b32 = ~req_b32;
    req_a64 = ~req_a64; req_b64 = ~req_b64;
    req_rd  = ~rd;
    lat = 0;
    while (!(w64 ? resp_valid64 : resp_valid32) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_latency"}, lat, exp_lat);
    check_val({tag, "_data"}, w64 ? resp_data64 : {32'b0, resp_data32}, exp);
    check_val({tag, "_rd"}, w64 ? resp_rd64 : resp_rd32, rd);
    @(posedge clk);
    #1;
    check_val({tag, "_handshake"}, w64 ? resp_valid64 : resp_valid32, 1'b0);
  endtask

  task automatic count_valid32(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (resp_valid32) seen++;
    end
  endtask

  initial begin
    int seen;
    int lat;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    kill = 1'b0;
    resp_ready = 1'b1;
    req_op = MD_MUL;
    req_rd = '0;
    req_valid32 = 1'b0; req_a32 = '0; req_b32 = '0;
    req_valid64 = 1'b0; req_a64 = '0; req_b64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid32", resp_valid32, 1'b0);
    check_val("rst_data32", resp_data32, 32'h0);
    check_val("rst_rd32", resp_rd32, 5'h0);
    check_val("rst_busy32", busy32, 1'b0);
    check_val("rst_ready32", req_ready32, 1'b1);
    check_val("rst_valid64", resp_valid64, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // multiply, XLEN=32, MUL_CYCLES=1
    run_op(0, "mulh_min_min",   MD_MULH,   64'h8000_0000, 64'h8000_0000, 5'd1, 64'h4000_0000, 1);
    run_op(0, "mul_min_min",    MD_MUL,    64'h8000_0000, 64'h8000_0000, 5'd2, 64'h0000_0000, 1);
    run_op(0, "mulhsu_ones",    MD_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, 64'hFFFF_FFFF, 1);
    run_op(0, "mulhu_ones",     MD_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE, 1);
    run_op(0, "mul_3_m2",       MD_MUL,    64'h0000_0003, 64'hFFFF_FFFE, 5'd5, 64'hFFFF_FFFA, 1);
    run_op(0, "mulh_3_m2",      MD_MULH,   64'h0000_0003, 64'hFFFF_FFFE, 5'd6, 64'hFFFF_FFFF, 1);

    // divide, normal path: XLEN+1 edges
    run_op(0, "div_m7_2",       MD_DIV,    64'hFFFF_FFF9, 64'h0000_0002, 5'd7,  64'hFFFF_FFFD, 33);
    run_op(0, "rem_m7_2",       MD_REM,    64'hFFFF_FFF9, 64'h0000_0002, 5'd8,  64'hFFFF_FFFF, 33);
    run_op(0, "divu_100_7",     MD_DIVU,   64'd100,       64'd7,         5'd9,  64'd14,        33);
    run_op(0, "remu_100_7",     MD_REMU,   64'd100,       64'd7,         5'd10, 64'd2,         33);
    run_op(0, "div_20_m3",      MD_DIV,    64'd20,        64'hFFFF_FFFD, 5'd11, 64'hFFFF_FFFA, 33);
    run_op(0, "rem_20_m3",      MD_REM,    64'd20,        64'hFFFF_FFFD, 5'd12, 64'd2,         33);

    // fast paths: result valid in the cycle right after the accepting edge
    run_op(0, "divu_5_0",       MD_DIVU,   64'd5,         64'd0,         5'd13, 64'hFFFF_FFFF, 0);
    run_op(0, "rem_m5_0",       MD_REM,    64'hFFFF_FFFB, 64'd0,         5'd14, 64'hFFFF_FFFB, 0);
    run_op(0, "div_ovf",        MD_DIV,    64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'h8000_0000, 0);
    run_op(0, "rem_ovf",        MD_REM,    64'h8000_0000, 64'hFFFF_FFFF, 5'd16, 64'h0,         0);

    // backpressure: result held for 5 cycles with resp_ready low
    @(negedge clk);
    resp_ready = 1'b0;
    req_op = MD_DIVU; req_a32 = 32'd100; req_b32 = 32'd7; req_rd = 5'd9; req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    lat = 0;
    while (!resp_valid32 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("bp_latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("bp_hold_valid_%0d", i), resp_valid32, 1'b1);
      check_val($sformatf("bp_hold_data_%0d", i), resp_data32, 32'd14);
      check_val($sformatf("bp_hold_rd_%0d", i), resp_rd32, 5'd9);
      check_val($sformatf("bp_hold_ready_%0d", i), req_ready32, 1'b0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_release_valid", resp_valid32, 1'b0);
    check_val("bp_release_ready", req_ready32, 1'b1);

    // kill while holding an unaccepted result drops it
    run_op(0, "pre_kill_done", MD_MUL, 64'd6, 64'd7, 5'd3, 64'd42, 1);
    @(negedge clk);
    resp_ready = 1'b0;
    req_op = MD_MUL; req_a32 = 32'd5; req_b32 = 32'd5; req_rd = 5'd4; req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    @(posedge clk);
    #1;
    check_val("killdone_valid_before", resp_valid32, 1'b1);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    resp_ready = 1'b1;
    check_val("killdone_valid_after", resp_valid32, 1'b0);
    check_val("killdone_busy", busy32, 1'b0);

    // kill at iteration 10 of a DIV; the next request goes in straight away
    @(negedge clk);
    req_op = MD_DIV; req_a32 = 32'd1000; req_b32 = 32'd3; req_rd = 5'd20; req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_val("kill_div_valid", resp_valid32, 1'b0);
    check_val("kill_div_busy", busy32, 1'b0);
    check_val("kill_div_ready", req_ready32, 1'b1);
    run_op(0, "after_kill_divu", MD_DIVU, 64'd100, 64'd7, 5'd21, 64'd14, 33);

    // kill in IDLE beats a same-cycle request
    @(negedge clk);
    kill = 1'b1;
    req_op = MD_MUL; req_a32 = 32'd3; req_b32 = 32'd5; req_rd = 5'd22; req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    req_valid32 = 1'b0;
    check_val("kill_idle_busy", busy32, 1'b0);
    count_valid32(4, seen);
    check_val("kill_idle_no_resp", seen, 0);

    // reset in the middle of a DIV
    @(negedge clk);
    req_op = MD_DIV; req_a32 = 32'd1000; req_b32 = 32'd3; req_rd = 5'd23; req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("midrst_valid", resp_valid32, 1'b0);
    check_val("midrst_data", resp_data32, 32'h0);
    check_val("midrst_rd", resp_rd32, 5'h0);
    check_val("midrst_busy", busy32, 1'b0);
    check_val("midrst_ready", req_ready32, 1'b1);
    count_valid32(40, seen);
    check_val("midrst_no_resp", seen, 0);

    // XLEN=64, MUL_CYCLES=3
    run_op(1, "div64_min_3",  MD_DIV,   64'h8000_0000_0000_0000, 64'd3, 5'd24, 64'hD555_5555_5555_5556, 65);
    run_op(1, "rem64_min_3",  MD_REM,   64'h8000_0000_0000_0000, 64'd3, 5'd25, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op(1, "mulhu64_ones", MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd26,
           64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op(1, "mul64_ones",   MD_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd27,
           64'h0000_0000_0000_0001, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
